// File: rtl/shift_rx.sv
// rtl/shift_rx.sv - serial-to-parallel receiver with synchronized sck/sdat/oe/clrn bundle
// Frames are latched on the falling edge of oe; the word is accepted only if exactly WIDTH bits were clocked in.
module shift_rx #(
  parameter int WIDTH = 16,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sin,
  output logic [WIDTH-1:0] pdata,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);
  // Idle pin levels {sck, sdat, oe, clrn}
  localparam logic [3:0]    IDLE_LVL = 4'b0011;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [3:0]       r_sync [SYNC];
  logic [3:0]       r_hist;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pdata;
  logic             r_valid;
  logic             r_ferr;
  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       w_s;
  logic             w_sck_rise;
  logic             w_oe_fall;
  logic             w_clr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) r_sync[i] <= IDLE_LVL;
      r_hist <= IDLE_LVL;
    end else begin
      r_sync[0] <= sin;
      for (int i = 1; i < SYNC; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= r_sync[SYNC-1];
    end
  end

  assign w_s        = r_sync[SYNC-1];
  assign w_sck_rise = w_s[3] & ~r_hist[3];
  assign w_oe_fall  = ~w_s[1] & r_hist[1];
  assign w_clr      = ~w_s[0];

  // Shift happens before the latch check so a same-cycle sck rise counts toward the frame
  always_comb begin
    w_sr_nxt  = r_sr;
    w_cnt_nxt = r_cnt;
    if (w_sck_rise) begin
      w_sr_nxt = {r_sr[WIDTH-2:0], w_s[2]};
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr || w_oe_fall) w_state_nxt = S_IDLE;
    else if (w_sck_rise)    w_state_nxt = S_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_pdata <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_clr) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (w_oe_fall) begin
        r_sr  <= '0;
        r_cnt <= '0;
        if (w_cnt_nxt == CNT_FULL) begin
          r_pdata <= w_sr_nxt;
          r_valid <= 1'b1;
        end else begin
          r_ferr <= 1'b1;
        end
      end else begin
        r_sr  <= w_sr_nxt;
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign pdata     = r_pdata;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state == S_SHIFT);

endmodule
